// File: rtl/tc_psum_pingpong.sv
// Two-bank partial-sum accumulator for the tensor-core output stage.
// One bank accumulates column slices while the other drains row by row, clearing each row as it is read.
module tc_psum_pingpong #(
   parameter int M      = 16,
   parameter int N      = 16,
   parameter int TILE_M = 4,
   parameter int DW_IN  = 8,
   parameter int DW_ACC = 16,
   parameter int DW_POS = 5,
   parameter bit SAT    = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DW_POS-1:0]        in_row,
   input  logic [DW_POS-1:0]        in_col,
   input  logic [TILE_M*DW_IN-1:0]  in_data,
   input  logic                     tile_done,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW_POS-1:0]        out_row,
   output logic                     out_last,
   output logic [N*DW_ACC-1:0]      out_data
);
   // state | meaning
   // FREE  | bank empty, next accepted beat starts a tile
   // ACC   | bank holds a partial tile and keeps accumulating
   // DRAIN | tile complete, waiting for or undergoing row readout
   typedef enum logic [1:0] {FREE, ACC, DRAIN} bank_st_t;

   localparam int RW = $clog2(M);
   localparam int CW = $clog2(N);

   logic signed [DW_ACC-1:0] acc [2][M][N];
   bank_st_t                 st [2];
   logic [1:0]               drain_rdy;
   logic                     w;
   logic                     rd;
   logic                     ob;
   logic [RW-1:0]            rp;
   logic                     accept;
   logic                     load;
   logic [RW-1:0]            lane_row [TILE_M];
   logic [TILE_M-1:0]        lane_ok;
   logic [CW-1:0]            col_idx;

   function automatic logic signed [DW_ACC-1:0] add_lane(
      input logic signed [DW_ACC-1:0] a,
      input logic signed [DW_IN-1:0]  b
   );
      logic signed [DW_ACC:0] s;
      s = {a[DW_ACC-1], a} + {{(DW_ACC+1-DW_IN){b[DW_IN-1]}}, b};
      if (SAT && (s[DW_ACC] != s[DW_ACC-1]))
         return s[DW_ACC] ? {1'b1, {(DW_ACC-1){1'b0}}} : {1'b0, {(DW_ACC-1){1'b1}}};
      return s[DW_ACC-1:0];
   endfunction

   assign in_ready = !rst && (st[w] != DRAIN);
   assign accept   = in_valid && in_ready;
   // drain_rdy lags the DRAIN state by one cycle so a freshly closed tile
   // starts its readout two edges after the closing beat.
   assign load     = drain_rdy[rd] && (st[rd] == DRAIN) && (!out_valid || out_ready);

   // Lanes falling past the last row are dropped rather than wrapped.
   always_comb begin
      col_idx = CW'(in_col);
      for (int i = 0; i < TILE_M; i++) begin
         lane_row[i] = RW'(int'(in_row) + i);
         lane_ok[i]  = (int'(in_row) + i < M) && (int'(in_col) < N);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
               acc[0][r][c] <= '0;
               acc[1][r][c] <= '0;
            end
         end
         st[0]     <= FREE;
         st[1]     <= FREE;
         drain_rdy <= 2'b00;
         w         <= 1'b0;
         rd        <= 1'b0;
         ob        <= 1'b0;
         rp        <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         drain_rdy <= {st[1] == DRAIN, st[0] == DRAIN};

         if (accept) begin
            for (int i = 0; i < TILE_M; i++) begin
               if (lane_ok[i])
                  acc[w][lane_row[i]][col_idx] <=
                     add_lane(acc[w][lane_row[i]][col_idx], in_data[i*DW_IN +: DW_IN]);
            end
            if (tile_done) begin
               st[w] <= DRAIN;
               w     <= ~w;
            end else if (st[w] == FREE) begin
               st[w] <= ACC;
            end
         end

         // The accepting bank is never DRAIN, so it cannot collide with ob.
         if (out_valid && out_ready && out_last)
            st[ob] <= FREE;

         if (load) begin
            for (int j = 0; j < N; j++) begin
               out_data[j*DW_ACC +: DW_ACC] <= acc[rd][rp][j];
               acc[rd][rp][j]               <= '0;
            end
            out_valid <= 1'b1;
            out_row   <= DW_POS'(rp);
            out_last  <= (rp == RW'(M-1));
            ob        <= rd;
            if (rp == RW'(M-1)) begin
               rp <= '0;
               rd <= ~rd;
            end else begin
               rp <= rp + 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/tc_psum_pingpong.md
Name: tc_psum_pingpong

Overview:
Double-buffered partial-sum accumulator for the tensor-core output stage. Accepts TILE_M-lane column slices of partial products and accumulates them into an M x N tile at a widened accumulator width, with optional saturation. The tile then drains row by row over a valid/ready stream. Two banks allow the next tile to accumulate while the previous one drains, and each row is cleared as it is read.

Parameters:
M  16  rows per output tile
N  16  columns per output tile
TILE_M  4  rows updated per input beat
DW_IN  8  signed input lane width
DW_ACC  16  signed accumulator width (must be >= DW_IN)
DW_POS  5  row/col index width; must cover indices up to M+TILE_M-1 and N-1
SAT  1  1 = saturate on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_row  in  DW_POS  base row; lane i targets row in_row+i
in_col  in  DW_POS  target column
in_data  in  TILE_M*DW_IN  signed lanes; lane i is bits [i*DW_IN +: DW_IN]
tile_done  in  1  qualifies an accepted beat as the last beat of the tile
out_valid  out  1  output row valid
out_ready  in  1  output row consumed when out_valid && out_ready
out_row  out  DW_POS  index of the row on out_data
out_last  out  1  high with row M-1
out_data  out  N*DW_ACC  column j is bits [j*DW_ACC +: DW_ACC]

Behaviour:
- Banks: two banks, B0 and B1. Each bank is FREE, ACC or DRAIN. Write pointer W selects the accumulating bank.
- Reset (sync, any state, including mid-drain):
  - all accumulators are set to 0, both banks go FREE, W=0;
  - out_valid=0, out_data=0, out_row=0, out_last=0;
  - in_ready=0 while rst is high and 1 from the first cycle after rst falls.
- in_ready is 1 when bank W is FREE or ACC, and 0 when bank W is DRAIN.
- Accepted beat, for each lane i:
  - if in_row+i < M and in_col < N: acc[W][in_row+i][in_col] <= acc + sign_extend(lane i);
  - lanes with in_row+i >= M are dropped (no wrap-around); the whole beat is dropped if in_col >= N.
  - Bank W goes FREE->ACC on its first accepted beat.
- Arithmetic:
  - SAT=1: clamp to [-2^(DW_ACC-1), 2^(DW_ACC-1)-1];
  - SAT=0: wrap modulo 2^DW_ACC.
- Back-to-back beats to the same element in consecutive cycles must both accumulate (single-cycle read-modify-write, no lost update).
- tile_done on an accepted beat:
  - the beat is accumulated, then bank W goes to DRAIN and W toggles;
  - if the new W bank is still DRAIN, in_ready drops until its drain completes.
  - tile_done without an accepted beat is ignored.
- Drain:
  - when a bank enters DRAIN and no other drain is active, row 0 is loaded into the registered output;
  - out_valid rises 2 cycles after the accepting edge of the tile_done beat.
  - Rows are emitted 0..M-1 in order, one per handshake, at full throughput of one row per cycle while out_ready=1.
  - While out_valid && !out_ready, out_data, out_row and out_last hold stable.
  - Each row is zeroed in the bank when it is loaded for output.
  - After the row M-1 handshake the bank goes FREE. If the other bank is already DRAIN, its row 0 appears on the next cycle with no bubble; otherwise out_valid drops.
- Drains are serviced strictly in tile completion order.
- Accumulation into bank W and drain of the other bank proceed concurrently with no interaction.

Test Plan:
1. Single beat, row 0, col 3, lanes {1,2,3,4}, tile_done, out_ready=1 -> out_valid 2 cycles later; 16 rows; rows 0..3 col 3 = 1,2,3,4, all else 0; out_last only on row 15.
2. 10 beats at row 4, col 0, all lanes 127, last beat with tile_done -> rows 4..7 col 0 = 1270, rest 0.
3. SAT=1: 300 beats of +127 -> 32767, and 300 beats of -128 -> -32768. SAT=0: 300 x 127 -> -27436.
4. Ping-pong with out_ready=0:
   - tile A done; tile B fully accepted with in_ready=1; tile B done; first beat of tile C stalls with in_ready=0.
   - Release out_ready -> A's 16 rows, then B's 16 rows with no bubble.
   - Tile C (one beat of 5) drains with only that element = 5, proving clear-on-read.
5. Random out_ready toggling over 3 tiles -> no skipped or duplicated rows; out_data stable during every stall; 48 rows total.
6. Boundary and reset:
   - in_row=14, TILE_M=4, lanes {7,8,9,10} -> rows 14,15 = 7,8; lanes 9,10 dropped.
   - rst asserted at row 5 of a drain -> out_valid=0 the next cycle; a following tile drains from row 0 with only its own values.
